alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Multi-cycle controller that sequences one register-to-register ALU instruction through the 8-bit ALU datapath.
- Accepts an instruction over a valid/ready handshake and reads Rs and Rd through a single shared register-file read port.
- Drives the ALU select and operand inputs, captures the result, writes it back to Rd, and maintains a zero flag.
- Sits between the instruction decode stage and the ALU/register file.

Parameters:
- DW, 8, data width of register file, ALU operands and result.
- RAW, 2, register address width; instruction width is 4+2*RAW.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  instruction present.
- in_instr  input  4+2*RAW  [top 4]=op, [next RAW]=rd, [low RAW]=rs.
- in_ready  output  1  controller can accept an instruction.
- rf_raddr  output  RAW  register-file read address (combinational read).
- rf_rdata  input  DW  register-file read data, same cycle as rf_raddr.
- rf_we  output  1  register-file write enable.
- rf_waddr  output  RAW  write address.
- rf_wdata  output  DW  write data.
- alu_s  output  4  ALU operation select.
- alu_x  output  DW  ALU Rs operand (registered).
- alu_bus  output  DW  ALU Rd operand (registered).
- alu_dout  input  DW  ALU result (combinational from alu_s/alu_x/alu_bus).
- done  output  1  one-cycle pulse in the writeback cycle.
- err  output  1  one-cycle pulse for an illegal opcode.
- zero  output  1  sticky zero flag from the last legal instruction.

Behaviour:
- Reset: state=IDLE; ir, x_reg, bus_reg, res all 0; zero=0. All outputs are 0 except in_ready=1.
- Opcodes: 0 clear, 1 add, 2 sub, 3 inc, 4 dec, 5 and, 6 or, 7 not, 8 xor; 9-15 are illegal.
- Operand needs:
  - op 0 needs no operand.
  - ops 3, 4, 7 need Rs only.
  - ops 1, 2, 5, 6, 8 need Rs and Rd.
- IDLE: in_ready=1. On in_valid, latch in_instr into ir and clear bus_reg to 0, then go to:
  - ERR if the opcode is illegal;
  - RS if the opcode needs Rs;
  - EX otherwise.
  - No accept while not IDLE; in_ready=0 there.
- RS: rf_raddr=ir.rs; x_reg<=rf_rdata. Next state is RD if the opcode needs Rd, else EX.
- RD: rf_raddr=ir.rd; bus_reg<=rf_rdata. Next state is EX.
- EX: alu_s=ir.op; alu_x=x_reg, alu_bus=bus_reg; res<=alu_dout; zero<=(alu_dout==0). Next state is WB.
- WB: rf_we=1, rf_waddr=ir.rd, rf_wdata=res, done=1. Next state is IDLE.
- ERR: err=1 for one cycle; no rf_we; zero and res are unchanged. Next state is IDLE.
- Idle output values:
  - alu_s=0 outside EX;
  - rf_raddr=0 outside RS/RD;
  - rf_waddr/rf_wdata=0 outside WB.
- Arithmetic is modulo 2^DW (wrap-around, no carry out), and is performed by the ALU.
- Latency, counted in cycles after the accept cycle:
  - two-operand op: rf_we in cycle 4;
  - one-operand op: cycle 3;
  - clear: cycle 2;
  - illegal: err in cycle 1.
- in_ready returns high the cycle after WB or ERR.
- rd==rs is legal: Rs and Rd are read in separate cycles, both before writeback.
- rst asserted in any state: next state is IDLE and the in-flight instruction is dropped. No rf_we, done or err pulse follows, and zero is cleared. rst takes priority over a simultaneous in_valid.

Test Plan:
- R1=0x35, R2=0x0F; instr 0x16 (add rd=1 rs=2) -> RS/RD/EX/WB; rf_we at cycle 4 with waddr=1, wdata=0x44; zero=0; done pulse; in_ready=1 at cycle 5.
- R0=0x00, R3=0x01; instr 0x23 (sub rd=0 rs=3) -> wdata=0xFF (wrap); zero=0.
- R1=0xFF; instr 0x35 (inc rd=rs=1) -> RD state skipped; rf_we at cycle 3 with wdata=0x00; zero=1; alu_bus=0 during EX.
- instr 0x08 (clear rd=2) -> no rf_raddr activity; rf_we at cycle 2 with waddr=2, wdata=0x00; zero=1.
- instr 0x9A (illegal) after a zero=1 result -> err pulse at cycle 1; no rf_we or done; zero stays 1. Back-to-back in_valid is held off by in_ready=0.
- Add accepted, rst pulsed in RD -> no rf_we ever; state IDLE, in_ready=1 and zero=0 the cycle after reset. A new instruction accepted afterwards executes normally.

Source files
------------

// File: rtl/alu_op_sequencer_if.sv
// rtl/alu_op_sequencer_if.sv - instruction handshake, register-file and ALU signals of the sequencer
interface alu_op_sequencer_if #(
    parameter int DW  = 8,
    parameter int RAW = 2
);
    logic                 in_valid;
    logic [4+2*RAW-1:0]   in_instr;
    logic                 in_ready;
    logic [RAW-1:0]       rf_raddr;
    logic [DW-1:0]        rf_rdata;
    logic                 rf_we;
    logic [RAW-1:0]       rf_waddr;
    logic [DW-1:0]        rf_wdata;
    logic [3:0]           alu_s;
    logic [DW-1:0]        alu_x;
    logic [DW-1:0]        alu_bus;
    logic [DW-1:0]        alu_dout;
    logic                 done;
    logic                 err;
    logic                 zero;

    modport master (
        input  in_valid, in_instr, rf_rdata, alu_dout,
        output in_ready, rf_raddr, rf_we, rf_waddr, rf_wdata,
               alu_s, alu_x, alu_bus, done, err, zero
    );

    modport slave (
        output in_valid, in_instr, rf_rdata, alu_dout,
        input  in_ready, rf_raddr, rf_we, rf_waddr, rf_wdata,
               alu_s, alu_x, alu_bus, done, err, zero
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - multi-cycle controller running one reg-to-reg ALU instruction
module alu_op_sequencer #(
    parameter int DW  = 8,
    parameter int RAW = 2
) (
    input  logic                clk,
    input  logic                rst,
    alu_op_sequencer_if.master  sif
);
    localparam int IW = 4 + 2*RAW;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RS,
        S_RD,
        S_EX,
        S_WB,
        S_ERR
    } state_t;

    state_t          state_q;
    logic [IW-1:0]   ir_q;
    logic [DW-1:0]   x_q;
    logic [DW-1:0]   bus_q;
    logic [DW-1:0]   res_q;
    logic            zero_q;
    logic            in_ready_q;
    logic [RAW-1:0]  rf_raddr_q;
    logic            rf_we_q;
    logic [RAW-1:0]  rf_waddr_q;
    logic [3:0]      alu_s_q;
    logic            done_q;
    logic            err_q;

    logic [3:0]      in_op_d;
    logic [RAW-1:0]  in_rs_d;
    logic [3:0]      ir_op;
    logic [RAW-1:0]  ir_rd;

    assign in_op_d = sif.in_instr[IW-1 -: 4];
    assign in_rs_d = sif.in_instr[RAW-1:0];
    assign ir_op   = ir_q[IW-1 -: 4];
    assign ir_rd   = ir_q[2*RAW-1 -: RAW];

    function automatic logic op_legal(input logic [3:0] op);
        return op <= 4'd8;
    endfunction

    function automatic logic op_needs_rs(input logic [3:0] op);
        return (op != 4'd0) && (op <= 4'd8);
    endfunction

    function automatic logic op_needs_rd(input logic [3:0] op);
        return (op == 4'd1) || (op == 4'd2) || (op == 4'd5) ||
               (op == 4'd6) || (op == 4'd8);
    endfunction

    // Output registers are loaded with the values of the state being entered,
    // so the read address is already stable when RS/RD samples rf_rdata.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ir_q       <= '0;
            x_q        <= '0;
            bus_q      <= '0;
            res_q      <= '0;
            zero_q     <= 1'b0;
            in_ready_q <= 1'b1;
            rf_raddr_q <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            alu_s_q    <= 4'd0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (sif.in_valid) begin
                        ir_q       <= sif.in_instr;
                        bus_q      <= '0;
                        in_ready_q <= 1'b0;
                        if (!op_legal(in_op_d)) begin
                            state_q <= S_ERR;
                            err_q   <= 1'b1;
                        end else if (op_needs_rs(in_op_d)) begin
                            state_q    <= S_RS;
                            rf_raddr_q <= in_rs_d;
                        end else begin
                            state_q <= S_EX;
                            alu_s_q <= in_op_d;
                        end
                    end
                end
                S_RS: begin
                    x_q <= sif.rf_rdata;
                    if (op_needs_rd(ir_op)) begin
                        state_q    <= S_RD;
                        rf_raddr_q <= ir_rd;
                    end else begin
                        state_q    <= S_EX;
                        rf_raddr_q <= '0;
                        alu_s_q    <= ir_op;
                    end
                end
                S_RD: begin
                    bus_q      <= sif.rf_rdata;
                    rf_raddr_q <= '0;
                    alu_s_q    <= ir_op;
                    state_q    <= S_EX;
                end
                S_EX: begin
                    res_q      <= sif.alu_dout;
                    zero_q     <= (sif.alu_dout == '0);
                    alu_s_q    <= 4'd0;
                    rf_we_q    <= 1'b1;
                    rf_waddr_q <= ir_rd;
                    done_q     <= 1'b1;
                    state_q    <= S_WB;
                end
                S_WB: begin
                    rf_we_q    <= 1'b0;
                    rf_waddr_q <= '0;
                    done_q     <= 1'b0;
                    in_ready_q <= 1'b1;
                    state_q    <= S_IDLE;
                end
                S_ERR: begin
                    err_q      <= 1'b0;
                    in_ready_q <= 1'b1;
                    state_q    <= S_IDLE;
                end
                default: begin
                    in_ready_q <= 1'b1;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    assign sif.in_ready = in_ready_q;
    assign sif.rf_raddr = rf_raddr_q;
    assign sif.rf_we    = rf_we_q;
    assign sif.rf_waddr = rf_waddr_q;
    assign sif.rf_wdata = res_q & {DW{rf_we_q}};
    assign sif.alu_s    = alu_s_q;
    assign sif.alu_x    = x_q;
    assign sif.alu_bus  = bus_q;
    assign sif.done     = done_q;
    assign sif.err      = err_q;
    assign sif.zero     = zero_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - directed scoreboard bench for alu_op_sequencer
module tb_alu_op_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_op_sequencer_if #(.DW(8), .RAW(2)) sif ();
    alu_op_sequencer #(.DW(8), .RAW(2)) dut (.clk(clk), .rst(rst), .sif(sif));

    logic [7:0] rf [4];
    logic [7:0] alu_res;

    assign sif.rf_rdata = rf[sif.rf_raddr];
    assign sif.alu_dout = alu_res;

    always_comb begin
        alu_res = 8'h00;
        case (sif.alu_s)
            4'd1: alu_res = sif.alu_x + sif.alu_bus;
            4'd2: alu_res = sif.alu_bus - sif.alu_x;
            4'd3: alu_res = sif.alu_x + 8'd1;
            4'd4: alu_res = sif.alu_x - 8'd1;
            4'd5: alu_res = sif.alu_x & sif.alu_bus;
            4'd6: alu_res = sif.alu_x | sif.alu_bus;
            4'd7: alu_res = ~sif.alu_x;
            4'd8: alu_res = sif.alu_x ^ sif.alu_bus;
            default: alu_res = 8'h00;
        endcase
    end

    typedef struct {
        logic [1:0] addr;
        logic [7:0] data;
        logic       zero;
    } wb_t;

    wb_t sb[$];
    int  checks = 0;
    int  errors = 0;
    logic exp_zero = 1'b0;

    function automatic logic [7:0] exp_alu(input logic [3:0] op, input logic [7:0] rs_v, input logic [7:0] rd_v);
        case (op)
            4'd1: return rs_v + rd_v;
            4'd2: return rd_v - rs_v;
            4'd3: return rs_v + 8'd1;
            4'd4: return rs_v - 8'd1;
            4'd5: return rs_v & rd_v;
            4'd6: return rs_v | rd_v;
            4'd7: return ~rs_v;
            4'd8: return rs_v ^ rd_v;
            default: return 8'h00;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_instr(input logic [7:0] instr, input int lat, input bit chk_noraddr,
                             input bit chk_bus0, input bit hold);
        logic [3:0] op;
        logic [1:0] rd, rs;
        bit   legal;
        wb_t  e;
        int   we_cyc = -1, err_cyc = -1, we_cnt = 0, done_cnt = 0, err_cnt = 0;
        bit   raddr_act = 0;
        op = instr[7:4];
        rd = instr[3:2];
        rs = instr[1:0];
        legal = (op <= 4'd8);
        chk("ready_before", 32'(sif.in_ready), 32'd1);
        if (legal) begin
            e.addr = rd;
            e.data = exp_alu(op, rf[rs], rf[rd]);
            e.zero = (e.data == 8'h00);
            sb.push_back(e);
        end
        @(negedge clk);
        sif.in_valid = 1'b1;
        sif.in_instr = instr;
        @(posedge clk);
        #1;
        if (!hold) sif.in_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 2) sif.in_valid = 1'b0;
            if (c == 1) chk("busy_ready", 32'(sif.in_ready), 32'd0);
            if (sif.rf_raddr != 2'd0) raddr_act = 1;
            if (legal && c == lat - 1) begin
                chk("ex_alu_s", 32'(sif.alu_s), 32'(op));
                if (chk_bus0) chk("ex_bus0", 32'(sif.alu_bus), 32'd0);
            end
            if (sif.done) done_cnt++;
            if (sif.err) begin
                err_cnt++;
                if (err_cyc < 0) err_cyc = c;
            end
            if (sif.rf_we) begin
                we_cnt++;
                if (we_cyc < 0) we_cyc = c;
                if (sb.size() == 0) begin
                    chk("sb_nonempty", 32'd0, 32'd1);
                end else begin
                    e = sb.pop_front();
                    chk("wb_addr", 32'(sif.rf_waddr), 32'(e.addr));
                    chk("wb_data", 32'(sif.rf_wdata), 32'(e.data));
                    chk("wb_done", 32'(sif.done), 32'd1);
                    exp_zero = e.zero;
                    rf[sif.rf_waddr] = sif.rf_wdata;
                end
            end
            if (c == lat + 1) begin
                chk("ready_after", 32'(sif.in_ready), 32'd1);
                chk("zero_after", 32'(sif.zero), 32'(exp_zero));
            end
        end
        if (legal) begin
            chk("we_cycle", 32'(we_cyc), 32'(lat));
            chk("we_count", 32'(we_cnt), 32'd1);
            chk("done_count", 32'(done_cnt), 32'd1);
            chk("no_err", 32'(err_cnt), 32'd0);
        end else begin
            chk("err_cycle", 32'(err_cyc), 32'd1);
            chk("err_count", 32'(err_cnt), 32'd1);
            chk("illegal_no_we", 32'(we_cnt), 32'd0);
            chk("illegal_no_done", 32'(done_cnt), 32'd0);
        end
        if (chk_noraddr) chk("no_raddr", 32'(raddr_act), 32'd0);
    endtask

    initial begin
        int cnt;
        sif.in_valid = 1'b0;
        sif.in_instr = 8'h00;
        rf[0] = 8'h00; rf[1] = 8'h35; rf[2] = 8'h0F; rf[3] = 8'h01;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", 32'(sif.in_ready), 32'd1);
        chk("rst_we", 32'(sif.rf_we), 32'd0);
        chk("rst_done", 32'(sif.done), 32'd0);
        chk("rst_err", 32'(sif.err), 32'd0);
        chk("rst_zero", 32'(sif.zero), 32'd0);
        chk("rst_alu_s", 32'(sif.alu_s), 32'd0);
        chk("rst_raddr", 32'(sif.rf_raddr), 32'd0);
        chk("rst_alu_x", 32'(sif.alu_x), 32'd0);
        chk("rst_alu_bus", 32'(sif.alu_bus), 32'd0);
        chk("rst_wdata", 32'(sif.rf_wdata), 32'd0);

        run_instr(8'h16, 4, 0, 0, 0);
        run_instr(8'h23, 4, 0, 0, 0);
        rf[1] = 8'hFF;
        run_instr(8'h35, 3, 0, 1, 0);
        run_instr(8'h08, 2, 1, 0, 0);
        run_instr(8'h9A, 1, 1, 0, 1);

        rf[1] = 8'h35; rf[2] = 8'h0F;
        @(negedge clk);
        sif.in_valid = 1'b1;
        sif.in_instr = 8'h16;
        @(posedge clk);
        #1 sif.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        sif.in_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sif.in_valid = 1'b0;
        exp_zero = 1'b0;
        chk("post_rst_ready", 32'(sif.in_ready), 32'd1);
        chk("post_rst_zero", 32'(sif.zero), 32'd0);
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            if (sif.rf_we || sif.done || sif.err) cnt++;
            @(negedge clk);
        end
        chk("post_rst_quiet", 32'(cnt), 32'd0);

        run_instr(8'h16, 4, 0, 0, 0);
        run_instr(8'h4F, 3, 0, 1, 0);
        run_instr(8'h8E, 4, 0, 0, 0);
        run_instr(8'h71, 3, 0, 1, 0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end
endmodule
